mac_operand_buffer: RTL
=======================

// Module: mac_operand_buffer
// PURPOSE
//  Parametrised operand register file for the MAC datapath: one write port, NUM_RD registered read ports,
//  write-to-read bypass and a sequential clear engine that zeroes the array one entry per cycle.
//  Sits between the input loader and the MAC array; supplies multiplicand/multiplier operands each cycle.
// PARAMETERS
//  DataWidth   8   bits per entry
//  BufferSize  4   number of entries (any value >= 2, need not be a power of two)
//  BufferWidth 2   address width, must equal clog2(BufferSize)
//  NUM_RD      2   number of independent read ports (>= 1)
// PORTS
//  clk          in   1                  rising-edge clock, single clock domain
//  reset        in   1                  asynchronous, active-low reset
//  clr_req      in   1                  pulse: start clear sequence
//  clr_busy     out  1                  high while clear sequence runs
//  wr_en        in   1                  write strobe
//  wr_addr      in   BufferWidth        write address
//  wr_data      in   DataWidth          write data
//  wr_perr_inj  in   1                  invert stored parity bit of this write (test only)
//  wr_drop      out  1                  1-cycle pulse: write rejected (busy or addr >= BufferSize)
//  rd_en        in   NUM_RD             per-port read strobe
//  rd_addr      in   NUM_RD*BufferWidth port p uses bits [p*BufferWidth +: BufferWidth]
//  rd_data      out  NUM_RD*DataWidth   port p uses bits [p*DataWidth +: DataWidth]
//  rd_valid     out  NUM_RD             rd_data of port p valid this cycle
//  rd_perr      out  NUM_RD             parity mismatch on port p (qualified by rd_valid)
// BEHAVIOUR
//  - Reset (reset=0, async): clr_busy=1, FSM=CLEAR, clr_ptr=0, rd_data=0, rd_valid=0, rd_perr=0, wr_drop=0.
//    Array contents are not reset directly; the CLEAR state zeroes them after reset deassertion.
//  - FSM IDLE/CLEAR. IDLE: clr_req=1 -> CLEAR, clr_ptr=0. CLEAR: write 0 (good parity) to clr_ptr each cycle,
//    clr_ptr++; at clr_ptr==BufferSize-1 the final zero write occurs and FSM -> IDLE next cycle.
//    Clear takes exactly BufferSize cycles; clr_busy is high for all of them. clr_req in CLEAR ignored (no restart).
//  - Write: in IDLE, wr_en=1 and wr_addr<BufferSize -> entry updated at the clock edge.
//    wr_en=1 while clr_busy=1 or wr_addr>=BufferSize -> no update, wr_drop=1 the following cycle.
//  - Read: latency 1. rd_en[p]=1 in cycle N -> rd_valid[p]=1 and rd_data[p] in cycle N+1; rd_en[p]=0 ->
//    rd_valid[p]=0 and rd_data[p] holds its last value. Out-of-range rd_addr returns 0, rd_valid still 1.
//  - Bypass: a read in the same cycle as an accepted write (user or clear engine) to the same address
//    returns the new data (write-first). All ports may read the same address simultaneously.
//  - Reset asserted mid-clear or mid-read: outputs return to reset values immediately; clear restarts at 0.
// CONFIGURATION
//  MAC_BUF_PARITY_EN defined: one even-parity bit stored per entry; wr_perr_inj inverts it on write;
//    rd_perr[p]=1 with rd_valid[p] when recomputed parity mismatches. Bypassed reads use the written parity.
//  Not defined: no parity storage; wr_perr_inj ignored; rd_perr tied to 0.
// STRUCTURE
//  mac_buf_pkg: clog2 function, FSM state typedef (ST_IDLE, ST_CLEAR), parity helper function.
//  Sub-module mac_buf_rd_port: one registered read port (addr range check, bypass mux, parity check,
//    valid/data registers); instantiated NUM_RD times in a generate loop. Array + FSM in the top.
// TESTING
//  1 Reset release, defaults -> clr_busy high exactly 4 cycles; afterwards read all 4 addrs -> 0, rd_perr=0.
//  2 Write 0xA5 @1, 0x3C @2; next cycle port0 rd @1, port1 rd @2 -> 0xA5/0x3C one cycle later, rd_valid=2'b11.
//  3 Same-cycle wr 0x7E @3 and rd @3 on both ports -> both return 0x7E next cycle (bypass).
//  4 clr_req then wr_en @0 during clr_busy -> wr_drop pulse, entry 0 reads 0; second clr_req ignored.
//  5 BufferSize=5, BufferWidth=3: wr @6 -> wr_drop=1; rd @7 -> 0 with rd_valid=1.
//  6 MAC_BUF_PARITY_EN: wr 0x0F @0 with wr_perr_inj=1 -> read @0 gives rd_perr=1; clean rewrite -> rd_perr=0.
//    Without macro, same stimulus -> rd_perr=0. Also assert reset mid-clear -> restart, full 4-cycle clear.

Source files
------------

// File: rtl/mac_buf_pkg.sv
// Shared types and helpers for the MAC operand buffer.
package mac_buf_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } st_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mac_buf_rd_port.sv
// One registered read port: range check, write-first bypass, parity check.
// Parity checking is compiled in with MAC_BUF_PARITY_EN.
module mac_buf_rd_port
  import mac_buf_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int BufferSize  = 4,
  parameter int BufferWidth = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     i_rd_en,
  input  logic [BufferWidth-1:0]                   i_rd_addr,
  input  logic [(1<<BufferWidth)*DataWidth-1:0]    i_mem_data,
  input  logic [(1<<BufferWidth)-1:0]              i_mem_par,
  input  logic                                     i_wr_en,
  input  logic [BufferWidth-1:0]                   i_wr_addr,
  input  logic [DataWidth-1:0]                     i_wr_data,
  input  logic                                     i_wr_par,
  output logic                                     o_rd_valid,
  output logic [DataWidth-1:0]                     o_rd_data,
  output logic                                     o_rd_perr
);

  localparam logic [BufferWidth:0] LpSize = (BufferWidth+1)'(BufferSize);

  logic                 w_in_range;
  logic                 w_hit;
  logic                 w_par;
  logic                 w_perr;
  logic [DataWidth-1:0] w_data;
  logic                 r_rd_valid;
  logic                 r_rd_perr;
  logic [DataWidth-1:0] r_rd_data;

  assign w_in_range = {1'b0, i_rd_addr} < LpSize;
  assign w_hit      = i_wr_en && (i_wr_addr == i_rd_addr);

  // Write-first: a same-cycle write to this address wins over the array.
  always_comb begin
    w_data = '0;
    w_par  = 1'b0;
    if (w_hit) begin
      w_data = i_wr_data;
      w_par  = i_wr_par;
    end else if (w_in_range) begin
      w_data = i_mem_data[i_rd_addr*DataWidth +: DataWidth];
      w_par  = i_mem_par[i_rd_addr];
    end
  end

`ifdef MAC_BUF_PARITY_EN
  assign w_perr = even_par(64'(w_data)) != w_par;
`else
  logic w_unused_par;
  assign w_unused_par = w_par;
  assign w_perr       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_rd_perr  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      r_rd_perr  <= i_rd_en & w_perr;
      if (i_rd_en) r_rd_data <= w_data;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_perr  = r_rd_perr;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/mac_operand_buffer.sv
// Operand register file: one write port, NUM_RD registered read ports, clear engine.
// Optional per-entry even parity enabled by defining MAC_BUF_PARITY_EN.
module mac_operand_buffer
  import mac_buf_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int BufferSize  = 4,
  parameter int BufferWidth = clog2(BufferSize),
  parameter int NUM_RD      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr_req,
  output logic                          clr_busy,
  input  logic                          wr_en,
  input  logic [BufferWidth-1:0]        wr_addr,
  input  logic [DataWidth-1:0]          wr_data,
  input  logic                          wr_perr_inj,
  output logic                          wr_drop,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD*BufferWidth-1:0] rd_addr,
  output logic [NUM_RD*DataWidth-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_valid,
  output logic [NUM_RD-1:0]             rd_perr,
  output st_e                           dbg_state
);

  // Handshake: no backpressure. rd_en[p] in cycle N gives rd_valid[p]/rd_data[p] in N+1;
  // writes are fire-and-forget and wr_drop (one cycle later) is the only rejection notice.

  localparam int                   Depth  = 1 << BufferWidth;
  localparam logic [BufferWidth:0] LpSize = (BufferWidth+1)'(BufferSize);
  localparam logic [BufferWidth-1:0] LpLast = BufferWidth'(BufferSize - 1);

  st_e                      r_state;
  logic [BufferWidth-1:0]   r_clr_ptr;
  logic                     r_clr_busy;
  logic                     r_wr_drop;
  logic [DataWidth-1:0]     r_mem [BufferSize];

  logic                     w_wr_in_range;
  logic                     w_wr_ok;
  logic                     w_we;
  logic                     w_wpar;
  logic [BufferWidth-1:0]   w_waddr;
  logic [DataWidth-1:0]     w_wdata;
  logic [Depth*DataWidth-1:0] w_mem_data;
  logic [Depth-1:0]         w_mem_par;

  assign w_wr_in_range = {1'b0, wr_addr} < LpSize;
  assign w_wr_ok       = wr_en && !r_clr_busy && w_wr_in_range;

  // The clear engine owns the write port while clearing.
  always_comb begin
    w_we    = w_wr_ok;
    w_waddr = wr_addr;
    w_wdata = wr_data;
    w_wpar  = even_par(64'(wr_data)) ^ wr_perr_inj;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_ptr;
      w_wdata = '0;
      w_wpar  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_clr_busy <= 1'b1;
      r_wr_drop  <= 1'b0;
    end else begin
      r_wr_drop <= wr_en && (r_clr_busy || !w_wr_in_range);
      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_ptr == LpLast) begin
            r_state    <= ST_IDLE;
            r_clr_ptr  <= '0;
            r_clr_busy <= 1'b0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_ptr  <= '0;
          r_clr_busy <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

`ifdef MAC_BUF_PARITY_EN
  logic [BufferSize-1:0] r_par;
  always_ff @(posedge clk) begin
    if (w_we) r_par[w_waddr] <= w_wpar;
  end
`endif

  // Pad the flattened view to a power of two so read ports never index past it.
  for (genvar i = 0; i < Depth; i++) begin : g_flat
    if (i < BufferSize) begin : g_used
      assign w_mem_data[i*DataWidth +: DataWidth] = r_mem[i];
`ifdef MAC_BUF_PARITY_EN
      assign w_mem_par[i] = r_par[i];
`else
      assign w_mem_par[i] = 1'b0;
`endif
    end else begin : g_pad
      assign w_mem_data[i*DataWidth +: DataWidth] = '0;
      assign w_mem_par[i] = 1'b0;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    mac_buf_rd_port #(
      .DataWidth  (DataWidth),
      .BufferSize (BufferSize),
      .BufferWidth(BufferWidth)
    ) u_rd_port (
      .clk       (clk),
      .reset     (reset),
      .i_rd_en   (rd_en[p]),
      .i_rd_addr (rd_addr[p*BufferWidth +: BufferWidth]),
      .i_mem_data(w_mem_data),
      .i_mem_par (w_mem_par),
      .i_wr_en   (w_we),
      .i_wr_addr (w_waddr),
      .i_wr_data (w_wdata),
      .i_wr_par  (w_wpar),
      .o_rd_valid(rd_valid[p]),
      .o_rd_data (rd_data[p*DataWidth +: DataWidth]),
      .o_rd_perr (rd_perr[p])
    );
  end

  assign clr_busy  = r_clr_busy;
  assign wr_drop   = r_wr_drop;
  assign dbg_state = r_state;

endmodule
